puf_cr_controller: RTL and testbench

Parametrised challenge/response sequencer for the PUF evaluation path. It receives a command and a CHAL_W-bit challenge as a byte stream from the UART receiver. It drives the Gray-coded challenge and an evaluation enable into the PUF core, captures the RESP_W-bit response after a programmable settle time, and streams the response back byte-wise to the UART transmitter. A loopback mode replaces the PUF response with the raw received challenge for link checking, and malformed commands return an error byte.

---
 rtl/puf_cr_controller.sv | 203 ++++++++++++++++++++
 tb/tb_puf_cr_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_cr_controller.sv
// Challenge/response sequencer for the PUF evaluation path: receives a command
// and challenge over a byte stream, drives the PUF, and streams the response back.
module puf_cr_controller #(
  parameter int CHAL_W = 16,
  parameter int RESP_W = 32,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_drop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_enable,
  input  logic [RESP_W-1:0] puf_response,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_CHAL = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_TX      = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  localparam logic [7:0] CMD_EVAL = 8'hA0;
  localparam logic [7:0] CMD_LOOP = 8'hA1;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam logic [7:0]  CHAL_LAST   = 8'(CHAL_W / 8 - 1);
  localparam logic [7:0]  RESP_LAST   = 8'(RESP_W / 8 - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  function automatic logic [CHAL_W-1:0] bin2gray(input logic [CHAL_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [2:0]        state_q, state_d;
  logic              loop_mode_q, loop_mode_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [CHAL_W-1:0] chal_next_s;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [15:0]       settle_cnt_q, settle_cnt_d;
  logic [7:0]        tx_cnt_q, tx_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [CHAL_W-1:0] puf_chal_q, puf_chal_d;
  logic              puf_en_q, puf_en_d;
  logic              busy_q, busy_d;
  logic              rx_drop_q, rx_drop_d;

  // Challenge shift: the newest byte enters at the LSB end (MSB-first stream).
  assign chal_next_s = CHAL_W'({chal_q, rx_data});

  // Next-state logic for the sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    loop_mode_d  = loop_mode_q;
    byte_cnt_d   = byte_cnt_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    settle_cnt_d = settle_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    puf_chal_d   = puf_chal_q;
    puf_en_d     = puf_en_q;
    rx_drop_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == CMD_EVAL) || (rx_data == CMD_LOOP)) begin
            loop_mode_d = (rx_data == CMD_LOOP);
            byte_cnt_d  = 8'd0;
            state_d     = S_RX_CHAL;
          end else begin
            tx_data_d  = ERR_BYTE;
            tx_valid_d = 1'b1;
            state_d    = S_ERR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX_CHAL: begin
        if (rx_valid) begin
          chal_d     = chal_next_s;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_q == CHAL_LAST) begin
            if (loop_mode_q) begin
              resp_d     = RESP_W'(chal_next_s);
              tx_data_d  = resp_d[RESP_W-1 -: 8];
              tx_valid_d = 1'b1;
              tx_cnt_d   = 8'd0;
              state_d    = S_TX;
            end else begin
              puf_chal_d   = bin2gray(chal_next_s);
              puf_en_d     = 1'b1;
              settle_cnt_d = 16'd0;
              state_d      = S_EVAL;
            end
          end else begin
            state_d = S_RX_CHAL;
          end
        end else begin
          state_d = S_RX_CHAL;
        end
      end
      S_EVAL: begin
        rx_drop_d    = rx_valid;
        settle_cnt_d = settle_cnt_q + 16'd1;
        if (settle_cnt_q == SETTLE_LAST) begin
          puf_en_d   = 1'b0;
          resp_d     = puf_response;
          tx_data_d  = puf_response[RESP_W-1 -: 8];
          tx_valid_d = 1'b1;
          tx_cnt_d   = 8'd0;
          state_d    = S_TX;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_TX: begin
        rx_drop_d = rx_valid;
        if (tx_ready) begin
          if (tx_cnt_q == RESP_LAST) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            // Response register shifts left so the next byte is always at the top.
            resp_d    = resp_q << 8;
            tx_data_d = resp_d[RESP_W-1 -: 8];
            tx_cnt_d  = tx_cnt_q + 8'd1;
            state_d   = S_TX;
          end
        end else begin
          state_d = S_TX;
        end
      end
      S_ERR: begin
        rx_drop_d = rx_valid;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        puf_en_d   = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      loop_mode_q  <= 1'b0;
      byte_cnt_q   <= 8'd0;
      chal_q       <= '0;
      resp_q       <= '0;
      settle_cnt_q <= 16'd0;
      tx_cnt_q     <= 8'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      puf_chal_q   <= '0;
      puf_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      rx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      loop_mode_q  <= loop_mode_d;
      byte_cnt_q   <= byte_cnt_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      settle_cnt_q <= settle_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      puf_chal_q   <= puf_chal_d;
      puf_en_q     <= puf_en_d;
      busy_q       <= busy_d;
      rx_drop_q    <= rx_drop_d;
    end
  end

  assign rx_drop       = rx_drop_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign puf_challenge = puf_chal_q;
  assign puf_enable    = puf_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_puf_cr_controller.sv
// Directed bench for puf_cr_controller: evaluate, loopback, error, backpressure,
// overrun and mid-transfer reset, with hand-computed expected values.
module tb_puf_cr_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_drop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] puf_challenge;
  logic        puf_enable;
  logic [31:0] puf_response;
  logic        busy;

  int checks = 0;
  int errors = 0;

  puf_cr_controller #(.CHAL_W(16), .RESP_W(32), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_drop(rx_drop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .puf_challenge(puf_challenge), .puf_enable(puf_enable),
    .puf_response(puf_response), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; observation happens 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; puf_response = 32'h0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({tx_valid, tx_data, puf_challenge, puf_enable, busy, rx_drop} !== 29'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%0b data=%h chal=%h en=%0b busy=%0b drop=%0b, want all 0",
               tx_valid, tx_data, puf_challenge, puf_enable, busy, rx_drop);
    end
  endtask

  task automatic test_evaluate();
    logic [31:0] exp = 32'hDEADBEEF;
    tx_ready = 1'b1; puf_response = exp;
    send_byte(8'hA0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL eval_busy_rise: got %0b want 1", busy); end
    send_byte(8'h12);
    send_byte(8'h34);
    checks++;
    if (puf_challenge !== 16'h1B2E) begin
      errors++; $display("FAIL eval_gray: got %h want 1b2e", puf_challenge);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (puf_enable !== 1'b1 || tx_valid !== 1'b0) begin
        errors++; $display("FAIL eval_enable[%0d]: got en=%0b valid=%0b want en=1 valid=0", i, puf_enable, tx_valid);
      end
      tick();
    end
    checks++;
    if (puf_enable !== 1'b0) begin errors++; $display("FAIL eval_enable_fall: got %0b want 0", puf_enable); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[31-8*k -: 8]) begin
        errors++; $display("FAIL eval_byte[%0d]: got valid=%0b data=%h want 1/%h", k, tx_valid, tx_data, exp[31-8*k -: 8]);
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL eval_done: got valid=%0b busy=%0b want 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] exp = 32'h00001234;
    tx_ready = 1'b1; puf_response = 32'hCAFEF00D;
    send_byte(8'hA1);
    send_byte(8'h12);
    send_byte(8'h34);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[31-8*k -: 8] || puf_enable !== 1'b0) begin
        errors++; $display("FAIL loop_byte[%0d]: got valid=%0b data=%h en=%0b want 1/%h/0", k, tx_valid, tx_data, puf_enable, exp[31-8*k -: 8]);
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || puf_challenge !== 16'h1B2E) begin
      errors++; $display("FAIL loop_done: got valid=%0b busy=%0b chal=%h want 0/0/1b2e", tx_valid, busy, puf_challenge);
    end
  endtask

  task automatic test_error();
    logic [31:0] exp = 32'h01020304;
    tx_ready = 1'b0; puf_response = exp;
    send_byte(8'h55);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE || busy !== 1'b1) begin
      errors++; $display("FAIL err_byte: got valid=%0b data=%h busy=%0b want 1/ee/1", tx_valid, tx_data, busy);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      errors++; $display("FAIL err_hold: got valid=%0b data=%h want 1/ee", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_done: got valid=%0b busy=%0b want 0/0", tx_valid, busy);
    end
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h01);
    checks++;
    if (puf_challenge !== 16'h0001 || puf_enable !== 1'b1) begin
      errors++; $display("FAIL err_then_eval: got chal=%h en=%0b want 0001/1", puf_challenge, puf_enable);
    end
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[31-8*k -: 8]) begin
        errors++; $display("FAIL err_eval_byte[%0d]: got valid=%0b data=%h want 1/%h", k, tx_valid, tx_data, exp[31-8*k -: 8]);
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL err_eval_done: got valid=%0b want 0", tx_valid); end
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b1; puf_response = 32'hDEADBEEF;
    send_byte(8'hA0); send_byte(8'h12); send_byte(8'h34);
    repeat (4) tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hDE) begin
      errors++; $display("FAIL bp_first: got valid=%0b data=%h want 1/de", tx_valid, tx_data);
    end
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hAD) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%h want 1/ad", i, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    checks++;
    if (tx_data !== 8'hAD) begin errors++; $display("FAIL bp_release: got %h want ad", tx_data); end
    tick();
    checks++;
    if (tx_data !== 8'hBE) begin errors++; $display("FAIL bp_third: got %h want be", tx_data); end
    tick();
    checks++;
    if (tx_data !== 8'hEF) begin errors++; $display("FAIL bp_fourth: got %h want ef", tx_data); end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done: got valid=%0b busy=%0b want 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_overrun();
    tx_ready = 1'b1; puf_response = 32'hDEADBEEF;
    send_byte(8'hA0); send_byte(8'h12); send_byte(8'h34);
    repeat (4) tick();
    send_byte(8'hA0);
    checks++;
    if (rx_drop !== 1'b1 || tx_data !== 8'hAD) begin
      errors++; $display("FAIL ovr_drop: got drop=%0b data=%h want 1/ad", rx_drop, tx_data);
    end
    tick();
    checks++;
    if (rx_drop !== 1'b0 || tx_data !== 8'hBE) begin
      errors++; $display("FAIL ovr_once: got drop=%0b data=%h want 0/be", rx_drop, tx_data);
    end
    tick();
    checks++;
    if (tx_data !== 8'hEF) begin errors++; $display("FAIL ovr_fourth: got %h want ef", tx_data); end
    tick(); tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovr_idle: got valid=%0b busy=%0b want 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp = 32'hDEADBEEF;
    tx_ready = 1'b1; puf_response = exp;
    send_byte(8'hA0); send_byte(8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({tx_valid, tx_data, puf_challenge, puf_enable, busy, rx_drop} !== 29'd0) begin
      errors++; $display("FAIL rst_mid: got valid=%0b data=%h chal=%h en=%0b busy=%0b drop=%0b want all 0",
                         tx_valid, tx_data, puf_challenge, puf_enable, busy, rx_drop);
    end
    send_byte(8'hA0); send_byte(8'hAB); send_byte(8'hCD);
    checks++;
    if (puf_challenge !== 16'hFE2B) begin errors++; $display("FAIL rst_gray: got %h want fe2b", puf_challenge); end
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[31-8*k -: 8]) begin
        errors++; $display("FAIL rst_byte[%0d]: got valid=%0b data=%h want 1/%h", k, tx_valid, tx_data, exp[31-8*k -: 8]);
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_done: got valid=%0b busy=%0b want 0/0", tx_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_evaluate();
    test_loopback();
    test_error();
    test_backpressure();
    test_overrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
